// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: memory funct3 codes and grant select.
package mem_arb_pkg;

    localparam logic [2:0] F3_LB    = 3'b000;
    localparam logic [2:0] F3_LH    = 3'b001;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;
    localparam logic [2:0] F3_SB    = 3'b000;
    localparam logic [2:0] F3_SH    = 3'b001;
    localparam logic [2:0] F3_SW    = 3'b010;
    localparam logic [2:0] F3_FETCH = 3'b010;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IF   = 2'b01,
        GNT_D    = 2'b10
    } gnt_e;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry instruction word buffer with hit compare and store-overlap invalidation.
module ifetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [29:0] if_word,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic        d_gnt,
    input  logic        fill,
    input  logic [31:0] fill_data,
    output logic        hit,
    output logic [31:0] ibuf_data
);

    logic        ibuf_valid;
    logic [29:0] ibuf_addr;
    logic [29:0] d_hi_word;
    logic        st_touch;

    // Last byte of a word store lands in the next word unless the store is aligned.
    assign d_hi_word = d_addr[31:2] + 30'(|d_addr[1:0]);
    assign st_touch  = d_write & ((d_addr[31:2] == ibuf_addr) | (d_hi_word == ibuf_addr));

    // Suppressing the hit on any overlapping store (not just a granted one) keeps the
    // grant logic free of a loop; if that store then loses arbitration, IF is granted
    // and reads the same word from memory.
    assign hit = if_req & ibuf_valid & (if_word == ibuf_addr) & ~st_touch;

    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_valid <= 1'b0;
        end else if (fill) begin
            ibuf_valid <= 1'b1;
            ibuf_addr  <= if_word;
            ibuf_data  <= fill_data;
        end else if (st_touch && d_gnt) begin
            ibuf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and load/store.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_instr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_funct3,
    input  logic [31:0] m_rdata
);

    gnt_e             gnt;
    logic             hit;
    logic [31:0]      ibuf_data;
    logic [CNT_W-1:0] starve_cnt;
    logic             if_need;
    logic             d_req;
    logic             starved;

    assign if_need = if_req & ~hit;
    assign d_req   = d_read | d_write;
    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        gnt = GNT_NONE;
        if (if_need && d_req) gnt = starved ? GNT_IF : GNT_D;
        else if (if_need)     gnt = GNT_IF;
        else if (d_req)       gnt = GNT_D;
    end

    ifetch_buf u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_word   (if_addr[31:2]),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_gnt     (gnt == GNT_D),
        .fill      (gnt == GNT_IF),
        .fill_data (m_rdata),
        .hit       (hit),
        .ibuf_data (ibuf_data)
    );

    // Any path reaching the increment is an IF miss that lost to data.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || hit || gnt == GNT_IF) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        if_ready = 1'b0;
        if_instr = '0;
        d_ready  = 1'b0;
        d_rdata  = '0;
        m_read   = 1'b0;
        m_write  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_funct3 = '0;
        if (!rst) begin
            if (hit) begin
                if_ready = 1'b1;
                if_instr = ibuf_data;
            end
            case (gnt)
                GNT_IF: begin
                    m_read   = 1'b1;
                    m_funct3 = F3_FETCH;
                    m_addr   = if_addr;
                    if_ready = 1'b1;
                    if_instr = m_rdata;
                end
                GNT_D: begin
                    m_read   = d_read;
                    m_write  = d_write;
                    m_addr   = d_addr;
                    m_wdata  = d_wdata;
                    m_funct3 = d_funct3;
                    d_ready  = 1'b1;
                    d_rdata  = m_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed vector bench for unified_mem_arbiter with a small byte-memory model behind the port.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_funct3;
    logic [31:0] m_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.STARVE_LIMIT(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_ready(d_ready), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_funct3(m_funct3), .m_rdata(m_rdata)
    );

    // Little-endian byte memory, combinational read, write on posedge; reloaded on reset.
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = m_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    always_comb begin
        m_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
        case (m_funct3)
            3'b000:  m_rdata = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  m_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b100:  m_rdata = {24'd0, mem[a0]};
            3'b101:  m_rdata = {16'd0, mem[a1], mem[a0]};
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} <= 32'h00A00093;
            {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} <= 32'h11223344;
            {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} <= 32'h12345678;
            mem[8'h31] <= 8'h80;
            mem[8'h32] <= 8'h7F;
        end else if (m_write) begin
            mem[a0] <= m_wdata[7:0];
            if (m_funct3 != 3'b000) mem[a1] <= m_wdata[15:8];
            if (m_funct3 == 3'b010) begin
                mem[a2] <= m_wdata[23:16];
                mem[a3] <= m_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        d_read, d_write;
        logic [31:0] d_addr, d_wdata;
        logic [2:0]  d_f3;
        logic        e_if_ready;
        logic [31:0] e_if_instr;
        logic        e_d_ready;
        logic [31:0] e_d_rdata;
        logic        e_m_read, e_m_write;
        logic [31:0] e_m_addr, e_m_wdata;
        logic [2:0]  e_m_f3;
    } vec_t;

    function automatic vec_t mk(
        logic r, logic ifr, logic [31:0] ifa, logic dr, logic dw, logic [31:0] da,
        logic [31:0] dwd, logic [2:0] f3, logic eifr, logic [31:0] eins, logic edr,
        logic [31:0] erd, logic emr, logic emw, logic [31:0] ema, logic [31:0] emwd,
        logic [2:0] emf3);
        vec_t v;
        v.rst = r; v.if_req = ifr; v.if_addr = ifa; v.d_read = dr; v.d_write = dw;
        v.d_addr = da; v.d_wdata = dwd; v.d_f3 = f3;
        v.e_if_ready = eifr; v.e_if_instr = eins; v.e_d_ready = edr; v.e_d_rdata = erd;
        v.e_m_read = emr; v.e_m_write = emw; v.e_m_addr = ema; v.e_m_wdata = emwd;
        v.e_m_f3 = emf3;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, sample mid-low-phase, state commits at the next posedge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
        d_read = v.d_read; d_write = v.d_write; d_addr = v.d_addr;
        d_wdata = v.d_wdata; d_funct3 = v.d_f3;
        #2;
        chk("if_ready", idx, {31'd0, if_ready}, {31'd0, v.e_if_ready});
        chk("d_ready",  idx, {31'd0, d_ready},  {31'd0, v.e_d_ready});
        chk("m_read",   idx, {31'd0, m_read},   {31'd0, v.e_m_read});
        chk("m_write",  idx, {31'd0, m_write},  {31'd0, v.e_m_write});
        chk("m_addr",   idx, m_addr,  v.e_m_addr);
        chk("m_wdata",  idx, m_wdata, v.e_m_wdata);
        chk("m_funct3", idx, {29'd0, m_funct3}, {29'd0, v.e_m_f3});
        if (v.e_if_ready || v.rst) chk("if_instr", idx, if_instr, v.e_if_instr);
        if ((v.e_d_ready && v.d_read) || v.rst) chk("d_rdata", idx, d_rdata, v.e_d_rdata);
    endtask

    vec_t vecs [0:23];
    vec_t hv;

    initial begin
        // reset with both requesting: everything forced low
        vecs[0]  = mk(1,1,'h10,1,0,'h31,0,F3_LB,  0,0,0,0,            0,0,0,0,0);
        vecs[1]  = mk(1,1,'h10,1,0,'h31,0,F3_LB,  0,0,0,0,            0,0,0,0,0);
        // data wins three times over an IF miss, then IF is forced
        vecs[2]  = mk(0,1,'h10,1,0,'h31,0,F3_LB,  0,0,1,'hFFFFFF80,   1,0,'h31,0,F3_LB);
        vecs[3]  = mk(0,1,'h10,1,0,'h31,0,F3_LB,  0,0,1,'hFFFFFF80,   1,0,'h31,0,F3_LB);
        vecs[4]  = mk(0,1,'h10,1,0,'h31,0,F3_LB,  0,0,1,'hFFFFFF80,   1,0,'h31,0,F3_LB);
        vecs[5]  = mk(0,1,'h10,1,0,'h31,0,F3_LB,  1,'h00A00093,0,0,   1,0,'h10,0,F3_FETCH);
        // IF now hits the buffer while the load uses the port
        vecs[6]  = mk(0,1,'h10,1,0,'h31,0,F3_LHU, 1,'h00A00093,1,'h00007F80, 1,0,'h31,0,F3_LHU);
        vecs[7]  = mk(0,1,'h10,0,0,0,0,0,         1,'h00A00093,0,0,   0,0,0,0,0);
        vecs[8]  = mk(0,1,'h20,0,0,0,0,0,         1,'h11223344,0,0,   1,0,'h20,0,F3_FETCH);
        // aligned store onto the buffered word kills the hit and the entry
        vecs[9]  = mk(0,1,'h20,0,1,'h20,'hDEADBEEF,F3_SW, 0,0,1,0,     0,1,'h20,'hDEADBEEF,F3_SW);
        vecs[10] = mk(0,1,'h20,0,0,0,0,0,         1,'hDEADBEEF,0,0,   1,0,'h20,0,F3_FETCH);
        // misaligned store spanning into the buffered word
        vecs[11] = mk(0,0,0,0,1,'h1E,'hCAFEF00D,F3_SW,    0,0,1,0,     0,1,'h1E,'hCAFEF00D,F3_SW);
        vecs[12] = mk(0,1,'h20,0,0,0,0,0,         1,'hDEADCAFE,0,0,   1,0,'h20,0,F3_FETCH);
        // byte store to the next word leaves the entry alone
        vecs[13] = mk(0,1,'h20,0,1,'h24,'h55,F3_SB, 1,'hDEADCAFE,1,0, 0,1,'h24,'h55,F3_SB);
        vecs[14] = mk(0,1,'h20,0,0,0,0,0,         1,'hDEADCAFE,0,0,   0,0,0,0,0);
        vecs[15] = mk(0,0,0,1,0,'h24,0,F3_LW,     0,0,1,'h00000055,   1,0,'h24,0,F3_LW);
        vecs[16] = mk(0,0,0,0,0,0,0,0,            0,0,0,0,            0,0,0,0,0);
        // dropping if_req clears the starvation count
        vecs[17] = mk(0,1,'h40,1,0,'h10,0,F3_LW,  0,0,1,'h00A00093,   1,0,'h10,0,F3_LW);
        vecs[18] = mk(0,1,'h40,1,0,'h10,0,F3_LW,  0,0,1,'h00A00093,   1,0,'h10,0,F3_LW);
        vecs[19] = mk(0,0,'h40,1,0,'h10,0,F3_LW,  0,0,1,'h00A00093,   1,0,'h10,0,F3_LW);
        vecs[20] = mk(0,1,'h40,1,0,'h10,0,F3_LW,  0,0,1,'h00A00093,   1,0,'h10,0,F3_LW);
        vecs[21] = mk(0,1,'h40,1,0,'h10,0,F3_LW,  0,0,1,'h00A00093,   1,0,'h10,0,F3_LW);
        vecs[22] = mk(0,1,'h40,1,0,'h10,0,F3_LW,  0,0,1,'h00A00093,   1,0,'h10,0,F3_LW);
        vecs[23] = mk(0,1,'h40,1,0,'h10,0,F3_LW,  1,'h12345678,0,0,   1,0,'h40,0,F3_FETCH);

        for (int i = 0; i < 24; i++) apply(vecs[i], i);

        // mid-run reset must drop the buffered 0x40 entry
        hv = mk(1,1,'h40,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        apply(hv, 100);
        hv = mk(0,1,'h40,0,0,0,0,0, 1,'h12345678,0,0, 1,0,'h40,0,F3_FETCH);
        apply(hv, 101);
        hv = mk(0,1,'h40,0,0,0,0,0, 1,'h12345678,0,0, 0,0,0,0,0);
        apply(hv, 102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
